// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro used by the top: SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width; a one-bit counter is the minimum even for tiny widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor_bit.sv
// Combinational one-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated when x is less than y + bin.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles.
// One full-subtractor cell is reused every cycle with a registered borrow.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a signed-overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cell_d;
  logic cell_bout;
  logic accept;
  logic last_bit;
  logic release_result;

  assign accept         = (state_q == IDLE) && start_valid;
  assign last_bit       = (state_q == RUN) && (cnt_q == LAST_CNT);
  assign release_result = (state_q == DONE) && done_ready;

  // The single reused arithmetic cell, fed by the low bits of the shifters.
  full_subtractor_bit u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle, else hold.
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    if (accept) begin
      a_sh_d   = a;
      b_sh_d   = b;
      borrow_d = bin;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
      diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
      borrow_d  = cell_bout;
      cnt_d     = cnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: the shifters are plain flops, not a memory, so they are all reset;
    // a reset mid-operation must leave diff and bout at zero.
    if (rst) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
    end
  end

  // After the last RUN cycle the borrow register holds the final borrow out.
  assign diff = diff_sh_q;
  assign bout = borrow_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow = borrow into the MSB xor borrow out of it, taken on the MSB cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit)            ovf_d = borrow_q ^ cell_bout;
    else if (release_result) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  // Without the overflow output these decodes have no consumer.
  logic unused_ovf_decode;
  assign unused_ovf_decode = last_bit ^ release_result;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             done_valid;
  logic             done_ready;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .diff        (diff),
    .bout        (bout),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: handshake, latency measurement, result check, release.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] exp_diff, input logic exp_bout,
                       input logic exp_ovf);
    int lat;
    start_valid = 1'b1;
    a = av; b = bv; bin = bi;
    tick();
    start_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    check({tag, ".busy"}, {31'd0, start_ready}, 32'd0);
    lat = 0;
    while (done_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, lat, WIDTH);
    check({tag, ".diff"}, {24'd0, diff}, {24'd0, exp_diff});
    check({tag, ".bout"}, {31'd0, bout}, {31'd0, exp_bout});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`endif
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check({tag, ".released"}, {31'd0, done_valid}, 32'd0);
    check({tag, ".ready_again"}, {31'd0, start_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    check("rst.start_ready", {31'd0, start_ready}, 32'd1);
    check("rst.done_valid", {31'd0, done_valid}, 32'd0);
    check("rst.diff", {24'd0, diff}, 32'd0);
    check("rst.bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("rst.ovf", {31'd0, ovf}, 32'd0);
`endif

    // Basic vectors and arithmetic corners.
    do_op("op35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    do_op("op00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    do_op("op10_0F_b1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    do_op("op5A_5A", 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("op00_FF_b1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);

    // Stray start_valid/done_ready during RUN, then a held result in DONE.
    start_valid = 1'b1; a = 8'hC3; b = 8'h41; bin = 1'b0;
    tick();
    a = 8'h00; b = 8'hFF; bin = 1'b1;
    tick(); tick();
    done_ready = 1'b1;
    tick(); tick();
    start_valid = 1'b0; done_ready = 1'b0;
    tick(); tick(); tick(); tick();
    check("hold.done_valid", {31'd0, done_valid}, 32'd1);
    check("hold.diff", {24'd0, diff}, 32'h82);
    check("hold.bout", {31'd0, bout}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.stable_valid", {31'd0, done_valid}, 32'd1);
      check("hold.stable_diff", {24'd0, diff}, 32'h82);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("hold.released", {31'd0, done_valid}, 32'd0);
    check("hold.start_ready", {31'd0, start_ready}, 32'd1);

    // Reset on the fourth RUN cycle discards the operation.
    start_valid = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b0;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.start_ready", {31'd0, start_ready}, 32'd1);
    check("midrst.done_valid", {31'd0, done_valid}, 32'd0);
    check("midrst.diff", {24'd0, diff}, 32'd0);
    check("midrst.bout", {31'd0, bout}, 32'd0);
    do_op("opAA_55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

    // Signed overflow boundaries.
    do_op("op80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op("op7F_01", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_subtractor
